bundle_issue_controller: RTL and testbench
==========================================

// Module: bundle_issue_controller
// PURPOSE
//  Sequences each 32-bit VLIW bundle into the dual-issue datapath: slot A (ALU, [15:0]) and slot D (load/store, [31:16]).
//  - Gates PC advance and all register-file and data-memory write enables.
//  - Splits a bundle over two cycles when both slots write the same register.
//  - Stalls slot D on a req/ready data-memory handshake; halts on a HALT bundle.
//  - Sits between instruction memory and the register file / data memory; replaces the always-advance PC path.
// PARAMETERS
//  INSTR_W  32  bundle width (fixed encoding below)
//  REG_AW   4   register address width
//  CNT_W    16  width of the bundle_count and stall_count performance counters
// PORTS
//  CLK           in   1        clock, all state updates on rising edge
//  RESET         in   1        synchronous, active-high reset
//  bundle        in   INSTR_W  current bundle from instruction memory (addressed by PC)
//  mem_ready     in   1        data memory completes the access this cycle; tie 1 for single-cycle memory
//  pc_en         out  1        PC loads PC+1 at the next edge
//  rf_we_a       out  1        register write enable, slot A (ALU result -> rd)
//  rf_we_d       out  1        register write enable, slot D (load data -> reg)
//  mem_req       out  1        data-memory access request
//  mem_we        out  1        data-memory write (store); only asserted together with mem_req
//  halted        out  1        controller is in HALT
//  bundle_count  out  CNT_W    number of retired bundles (pc_en cycles), saturating
//  stall_count   out  CNT_W    number of non-halted cycles with pc_en=0, saturating
// BEHAVIOUR
//  Encoding:
//   - A: [15:13] alu ctrl, [12] a_valid, [11:8] rd, [7:4] rs1, [3:0] rs2.
//   - D: [31] reserved 0, [30:29] op (00 NOP, 01 LOAD, 10 STORE, 11 HALT), [28] mode (0 imm, 1 mem), [27:24] reg, [23:16] addr/imm.
//  Derived signals:
//   - d_mem   = STORE | (LOAD & mode=1).
//   - d_write = LOAD.
//   - waw     = a_valid & d_write & (rd == reg).
//  Operand semantics: both slots read pre-bundle register values; intra-bundle RAW needs no stall.
//  Output timing: enables are combinational from state + bundle (Mealy). Counters are registered.
//  RESET high: all enables and halted = 0 in that cycle; next state RUN; counters cleared to 0.
//  FSM states RUN, D_ONLY, HALT:
//   RUN:
//    - op=HALT -> no enables, pc_en=0, next HALT.
//    - waw -> rf_we_a=1 only, pc_en=0, next D_ONLY (program order A then D; D value wins).
//    - d_mem & !mem_ready -> rf_we_a=a_valid, mem_req=1, mem_we=STORE, no rf_we_d, pc_en=0, next D_ONLY.
//    - else full issue -> rf_we_a=a_valid, rf_we_d=d_write, mem_req=d_mem, mem_we=STORE, pc_en=1, stay RUN.
//   D_ONLY (slot A never re-issued):
//    - mem_req=d_mem, mem_we=STORE.
//    - if !d_mem | mem_ready: rf_we_d=d_write, pc_en=1, next RUN.
//    - else hold D_ONLY, no writes.
//   HALT: all enables 0, halted=1; exit only by RESET.
//  Memory handshake rules:
//   - A transfer completes on a cycle with mem_req & mem_ready.
//   - mem_req is held until then.
//   - mem_ready without mem_req is ignored.
//   - Load data is written only on the completing cycle.
//  Counters:
//   - bundle_count +1 on each pc_en cycle.
//   - stall_count +1 on each cycle that is not RESET, not HALT and has pc_en=0 (includes the HALT-detect cycle).
//   - Both saturate at all-ones.
//  Reset mid-operation: RESET in D_ONLY aborts the pending D (no write, no mem_req), PC unchanged by controller.
//  Bundle is assumed stable while pc_en=0 (PC frozen).
// STRUCTURE
//  Shared header vliw_defs.vh:
//   - D opcode constants, field bit positions.
//   - FSM state encodings (2-bit).
//  Sub-module bundle_decoder (combinational): field extraction, a_valid/d_write/d_mem/waw/is_halt.
//  Top: FSM + output decode + two saturating counters.
// TESTING
//  1. 0x22051123 (A rd1, D LOAD imm reg2), mem_ready=1 -> same cycle rf_we_a=1, rf_we_d=1, mem_req=0, pc_en=1; bundle_count=1.
//  2. 0x21051123 (WAW on r1) -> cyc0 rf_we_a=1, rf_we_d=0, pc_en=0; cyc1 rf_we_a=0, rf_we_d=1, pc_en=1; stall_count=1.
//  3. 0x43100000 (STORE r3 ->[0x10]), mem_ready low 2 cycles then high -> mem_req=mem_we=1 for 3 cycles; pc_en=1 only on 3rd; stall_count=2.
//  4. 0x60000000 (HALT) -> pc_en=0, halted=1 from next cycle; counters frozen for 10 cycles; RESET -> halted=0, counters 0.
//  5. RESET asserted in D_ONLY (test 3 after 1 wait cycle) -> no rf_we_d/mem_we that cycle; RUN afterwards; counters 0.
//  6. CNT_W=4, 20 back-to-back no-conflict bundles -> bundle_count stops at 15, no wrap.

Source files
------------

// File: rtl/bundle_issue_controller_pkg.sv
// rtl/bundle_issue_controller_pkg.sv - shared encodings, field positions and FSM states
package bundle_issue_controller_pkg;

    localparam int INSTR_W = 32;
    localparam int REG_AW  = 4;

    // Slot D opcodes
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    // Field bit positions within the bundle
    localparam int A_VALID_BIT = 12;
    localparam int A_RD_LO     = 8;
    localparam int D_OP_LO     = 29;
    localparam int D_MODE_BIT  = 28;
    localparam int D_REG_LO    = 24;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_D_ONLY = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // Per-bundle control summary produced by the decoder
    typedef struct packed {
        logic a_valid;
        logic d_write;
        logic d_store;
        logic d_mem;
        logic waw;
        logic is_halt;
    } dec_t;

endpackage

// File: rtl/bundle_issue_controller_if.sv
// rtl/bundle_issue_controller_if.sv - instruction/memory side handshake and enable bundle
interface bundle_issue_controller_if #(parameter int CNT_W = 16);
    import bundle_issue_controller_pkg::*;

    logic [INSTR_W-1:0] bundle;
    logic               mem_ready;
    logic               pc_en;
    logic               rf_we_a;
    logic               rf_we_d;
    logic               mem_req;
    logic               mem_we;
    logic               halted;
    logic [CNT_W-1:0]   bundle_count;
    logic [CNT_W-1:0]   stall_count;

    // Environment side: instruction memory, data memory, register file
    modport master (
        output bundle, mem_ready,
        input  pc_en, rf_we_a, rf_we_d, mem_req, mem_we, halted, bundle_count, stall_count
    );

    // Controller side
    modport slave (
        input  bundle, mem_ready,
        output pc_en, rf_we_a, rf_we_d, mem_req, mem_we, halted, bundle_count, stall_count
    );
endinterface

// File: rtl/bundle_issue_controller_decoder.sv
// rtl/bundle_issue_controller_decoder.sv - combinational bundle field decode
module bundle_issue_controller_decoder
    import bundle_issue_controller_pkg::*;
(
    input  logic [INSTR_W-1:0] bundle_i,
    output dec_t               dec_o
);
    logic [1:0]        d_op;
    logic              d_mode;
    logic [REG_AW-1:0] a_rd;
    logic [REG_AW-1:0] d_reg;
    logic              unused_fields;

    assign d_op   = bundle_i[D_OP_LO +: 2];
    assign d_mode = bundle_i[D_MODE_BIT];
    assign a_rd   = bundle_i[A_RD_LO +: REG_AW];
    assign d_reg  = bundle_i[D_REG_LO +: REG_AW];

    // ALU ctrl, source registers, addr/imm and the reserved bit only matter to the datapath
    assign unused_fields = ^{bundle_i[31], bundle_i[23:16], bundle_i[15:13], bundle_i[7:0]};

    // Derive the per-slot control summary
    always_comb begin
        dec_o         = '0;
        dec_o.a_valid = bundle_i[A_VALID_BIT];
        dec_o.d_write = (d_op == OP_LOAD);
        dec_o.d_store = (d_op == OP_STORE);
        dec_o.d_mem   = (d_op == OP_STORE) || ((d_op == OP_LOAD) && d_mode);
        dec_o.is_halt = (d_op == OP_HALT);
        dec_o.waw     = bundle_i[A_VALID_BIT] && (d_op == OP_LOAD) && (a_rd == d_reg);
    end
endmodule

// File: rtl/bundle_issue_controller.sv
// rtl/bundle_issue_controller.sv - dual-issue VLIW bundle sequencer with perf counters
module bundle_issue_controller
    import bundle_issue_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    bundle_issue_controller_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dec_t             dec;
    state_t           state_q, state_d;
    logic             pc_en, rf_we_a, rf_we_d, mem_req, mem_we, halted;
    logic [CNT_W-1:0] bundle_count_q, bundle_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    bundle_issue_controller_decoder u_decoder (
        .bundle_i (bus.bundle),
        .dec_o    (dec)
    );

    // Next state and Mealy enables; reset forces every enable low in its own cycle
    always_comb begin
        state_d = state_q;
        pc_en   = 1'b0;
        rf_we_a = 1'b0;
        rf_we_d = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        halted  = 1'b0;
        if (rst_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dec.is_halt) begin
                        state_d = ST_HALT;
                    end else if (dec.waw) begin
                        // A writes first, D retires next cycle so the load value wins
                        rf_we_a = 1'b1;
                        state_d = ST_D_ONLY;
                    end else if (dec.d_mem && !bus.mem_ready) begin
                        rf_we_a = dec.a_valid;
                        mem_req = 1'b1;
                        mem_we  = dec.d_store;
                        state_d = ST_D_ONLY;
                    end else begin
                        rf_we_a = dec.a_valid;
                        rf_we_d = dec.d_write;
                        mem_req = dec.d_mem;
                        mem_we  = dec.d_store;
                        pc_en   = 1'b1;
                    end
                end
                ST_D_ONLY: begin
                    // Slot A already retired; keep the request up until memory completes
                    mem_req = dec.d_mem;
                    mem_we  = dec.d_store;
                    if (!dec.d_mem || bus.mem_ready) begin
                        rf_we_d = dec.d_write;
                        pc_en   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating retire and stall counters
    always_comb begin
        bundle_count_d = bundle_count_q;
        stall_count_d  = stall_count_q;
        if (rst_i) begin
            bundle_count_d = '0;
            stall_count_d  = '0;
        end else begin
            if (pc_en && (bundle_count_q != CNT_MAX))
                bundle_count_d = bundle_count_q + 1'b1;
            if (!pc_en && (state_q != ST_HALT) && (stall_count_q != CNT_MAX))
                stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            bundle_count_q <= '0;
            stall_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            bundle_count_q <= bundle_count_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.rf_we_a      = rf_we_a;
    assign bus.rf_we_d      = rf_we_d;
    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.halted       = halted;
    assign bus.bundle_count = bundle_count_q;
    assign bus.stall_count  = stall_count_q;
endmodule

// File: tb/tb_bundle_issue_controller.sv
// tb/tb_bundle_issue_controller.sv - directed scoreboard bench for bundle_issue_controller
module tb_bundle_issue_controller;
    import bundle_issue_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bundle_issue_controller_if #(.CNT_W(16)) bus16 ();
    bundle_issue_controller_if #(.CNT_W(4))  bus4 ();

    bundle_issue_controller #(.CNT_W(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));
    bundle_issue_controller #(.CNT_W(4))  dut4  (.clk_i(clk), .rst_i(rst), .bus(bus4));

    typedef struct {
        string tag;
        logic  pc, wa, wd, rq, we, h;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare Mealy outputs, then let the edge commit
    task automatic step(input string tag, input logic [31:0] b, input logic rdy, input logic r,
                        input logic pc, input logic wa, input logic wd,
                        input logic rq, input logic we, input logic h);
        exp_t e;
        @(negedge clk);
        bus16.bundle = b;  bus16.mem_ready = rdy;
        bus4.bundle  = b;  bus4.mem_ready  = rdy;
        rst = r;
        sb.push_back('{tag, pc, wa, wd, rq, we, h});
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc_en"},   {31'b0, bus16.pc_en},   {31'b0, e.pc});
        chk({e.tag, ".rf_we_a"}, {31'b0, bus16.rf_we_a}, {31'b0, e.wa});
        chk({e.tag, ".rf_we_d"}, {31'b0, bus16.rf_we_d}, {31'b0, e.wd});
        chk({e.tag, ".mem_req"}, {31'b0, bus16.mem_req}, {31'b0, e.rq});
        chk({e.tag, ".mem_we"},  {31'b0, bus16.mem_we},  {31'b0, e.we});
        chk({e.tag, ".halted"},  {31'b0, bus16.halted},  {31'b0, e.h});
        @(posedge clk);
        #1;
    endtask

    task automatic cnt(input string tag, input int bc, input int sc);
        chk({tag, ".bundle_count"}, {16'b0, bus16.bundle_count}, bc);
        chk({tag, ".stall_count"},  {16'b0, bus16.stall_count},  sc);
    endtask

    initial begin
        bus16.bundle = '0; bus16.mem_ready = 1'b1;
        bus4.bundle  = '0; bus4.mem_ready  = 1'b1;

        // Reset gates enables even with an issuable bundle present
        step("rst0", 32'h22051123, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
        cnt("rst0", 0, 0);

        // Full dual issue, LOAD immediate
        step("t1", 32'h22051123, 1'b1, 1'b0, 1, 1, 1, 0, 0, 0);
        cnt("t1", 1, 0);

        // WAW split over two cycles
        step("t2c0", 32'h21051123, 1'b1, 1'b0, 0, 1, 0, 0, 0, 0);
        cnt("t2c0", 1, 1);
        step("t2c1", 32'h21051123, 1'b1, 1'b0, 1, 0, 1, 0, 0, 0);
        cnt("t2c1", 2, 1);

        // Store with two wait cycles
        step("t3c0", 32'h43100000, 1'b0, 1'b0, 0, 0, 0, 1, 1, 0);
        step("t3c1", 32'h43100000, 1'b0, 1'b0, 0, 0, 0, 1, 1, 0);
        step("t3c2", 32'h43100000, 1'b1, 1'b0, 1, 0, 0, 1, 1, 0);
        cnt("t3", 3, 3);

        // mem_ready low with no request is ignored
        step("aonly", 32'h00001123, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0);
        cnt("aonly", 4, 3);

        // Memory-mode load: A retires early, load data only on completing cycle
        step("ldm0", 32'h32051123, 1'b0, 1'b0, 0, 1, 0, 1, 0, 0);
        step("ldm1", 32'h32051123, 1'b1, 1'b0, 1, 0, 1, 1, 0, 0);
        cnt("ldm", 5, 4);

        // Same register numbers but slot A invalid: no WAW split
        step("nowaw", 32'h21050123, 1'b1, 1'b0, 1, 0, 1, 0, 0, 0);
        cnt("nowaw", 6, 4);

        // Reset while a store is pending in D_ONLY
        step("t5c0", 32'h43100000, 1'b0, 1'b0, 0, 0, 0, 1, 1, 0);
        step("t5rst", 32'h43100000, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
        cnt("t5rst", 0, 0);
        step("t5run", 32'h43100000, 1'b1, 1'b0, 1, 0, 0, 1, 1, 0);
        cnt("t5run", 1, 0);

        // HALT: detect cycle counts as a stall, then everything frozen
        step("t4det", 32'h60000000, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        cnt("t4det", 1, 1);
        for (int i = 0; i < 10; i++)
            step("t4hold", (i % 2 == 0) ? 32'h60000000 : 32'h22051123, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1);
        cnt("t4hold", 1, 1);
        step("t4rst", 32'h60000000, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
        cnt("t4rst", 0, 0);

        // Back-to-back issue: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++)
            step("t6", 32'h22051123, 1'b1, 1'b0, 1, 1, 1, 0, 0, 0);
        cnt("t6", 20, 0);
        chk("t6.bc4", {28'b0, bus4.bundle_count}, 32'd15);
        chk("t6.sc4", {28'b0, bus4.stall_count},  32'd0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
